// File: rtl/element_op_pkg.sv
// Shared types for the element-wise operator streaming block.
//   op_e    : 3-bit opcode (5..7 are unused and select an all-zero result)
//   state_e : stream FSM states
//   ELEM_W  : matrix element width
`ifndef WIDTH_BIT
`define WIDTH_BIT 2
`endif

package element_op_pkg;

    localparam int unsigned ELEM_W = 32;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpDiv = 3'd3,
        OpMod = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        StLoadA = 2'd0,
        StLoadB = 2'd1,
        StExec  = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/element_op_select.sv
// Combinational opcode mux over the five element-op result matrices.
// Config macro: ELEMENT_DIV0_GUARD_EN -- when defined, DIV elements with a zero
// divisor read all-ones, MOD elements read the dividend, and div0 flags it.
// Ports:
//   op                      : job opcode
//   mat_a, mat_b            : operand matrices (used by the divisor guard)
//   res_add .. res_mod      : element-op results
//   res                     : selected result matrix
//   div0                    : a DIV/MOD element had a zero divisor (guard only)
module element_op_select
    import element_op_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [2:0]                                op,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   mat_a,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   mat_b,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_add,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_sub,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_mul,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_div,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_mod,
    output logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res,
    output logic                                      div0
);

`ifndef ELEMENT_DIV0_GUARD_EN
    // Operands only matter to the guard.
    logic unused_operands;
    assign unused_operands = ^{mat_a, mat_b};
`endif

    always_comb begin
        res  = '0;
        div0 = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                case (op)
                    OpAdd: res[i][j] = res_add[i][j];
                    OpSub: res[i][j] = res_sub[i][j];
                    OpMul: res[i][j] = res_mul[i][j];
                    OpDiv: begin
                        res[i][j] = res_div[i][j];
`ifdef ELEMENT_DIV0_GUARD_EN
                        if (mat_b[i][j] == '0) begin
                            res[i][j] = '1;
                            div0      = 1'b1;
                        end
`endif
                    end
                    OpMod: begin
                        res[i][j] = res_mod[i][j];
`ifdef ELEMENT_DIV0_GUARD_EN
                        if (mat_b[i][j] == '0) begin
                            res[i][j] = mat_a[i][j];
                            div0      = 1'b1;
                        end
`endif
                    end
                    default: res[i][j] = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/element_op_stream.sv
// Streaming front/back end for the element-wise matrix operators.
// Loads A then B (row-major, one 32-bit word per beat), captures the selected
// result matrix for one cycle, then drains it word by word.
// Config macro: ELEMENT_DIV0_GUARD_EN (divisor-zero guard and err_div0 flag).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : operand word stream; in_op sampled on first A beat
//   mat_a, mat_b                  : registered operands to the element ops
//   res_add .. res_mod            : element-op results
//   out_valid/out_ready/out_data  : result word stream; out_last marks the final word
//   busy                          : high in EXEC and DRAIN
//   err_div0                      : divisor-zero flag for the current job
`ifndef WIDTH_BIT
`define WIDTH_BIT 2
`endif

module element_op_stream
    import element_op_pkg::*;
#(
    parameter int unsigned WIDTH = 2 ** `WIDTH_BIT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [ELEM_W-1:0]                         in_data,
    input  logic [2:0]                                in_op,
    output logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   mat_a,
    output logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   mat_b,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_add,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_sub,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_mul,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_div,
    input  logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   res_mod,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ELEM_W-1:0]                         out_data,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      err_div0
);

    localparam int unsigned WB = $clog2(WIDTH);
    localparam int unsigned IW = 2 * WB;
    localparam logic [IW-1:0] LastIdx = IW'(WIDTH * WIDTH - 1);

    state_e                                    state_q, state_d;
    logic [IW-1:0]                             idx_q, idx_d, idx_nxt;
    logic [2:0]                                op_q;
    logic [0:WIDTH-1][0:WIDTH-1][ELEM_W-1:0]   mat_a_q, mat_b_q, res_q, sel_res;
    logic                                      sel_div0;
    logic                                      out_valid_q, out_last_q, err_q;
    logic [ELEM_W-1:0]                         out_data_q;
    logic                                      in_fire, out_fire;

    // Index counter is exactly log2(N) bits, so +1 wraps to 0 at N.
    assign idx_nxt  = idx_q + 1'b1;
    assign in_ready = (state_q == StLoadA || state_q == StLoadB) && !rst;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign mat_a     = mat_a_q;
    assign mat_b     = mat_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == StExec) || (state_q == StDrain);
    assign err_div0  = err_q;

    element_op_select #(
        .WIDTH (WIDTH)
    ) u_select (
        .op      (op_q),
        .mat_a   (mat_a_q),
        .mat_b   (mat_b_q),
        .res_add (res_add),
        .res_sub (res_sub),
        .res_mul (res_mul),
        .res_div (res_div),
        .res_mod (res_mod),
        .res     (sel_res),
        .div0    (sel_div0)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StLoadA: begin
                if (in_fire) begin
                    if (idx_q == LastIdx) begin
                        state_d = StLoadB;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            StLoadB: begin
                if (in_fire) begin
                    if (idx_q == LastIdx) begin
                        state_d = StExec;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            StExec: begin
                state_d = StDrain;
                idx_d   = '0;
            end
            StDrain: begin
                if (out_fire) begin
                    if (idx_q == LastIdx) begin
                        state_d = StLoadA;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            default: begin
                state_d = StLoadA;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoadA;
            idx_q       <= '0;
            op_q        <= '0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;

            if (in_fire && state_q == StLoadA) begin
                mat_a_q[idx_q[IW-1:WB]][idx_q[WB-1:0]] <= in_data;
                if (idx_q == '0) begin
                    op_q  <= in_op;
                    err_q <= 1'b0;
                end
            end
            if (in_fire && state_q == StLoadB) begin
                mat_b_q[idx_q[IW-1:WB]][idx_q[WB-1:0]] <= in_data;
            end

            // Capture the result and preload word 0 so out_valid rises next cycle.
            if (state_q == StExec) begin
                res_q       <= sel_res;
                err_q       <= sel_div0;
                out_valid_q <= 1'b1;
                out_data_q  <= sel_res[0][0];
                out_last_q  <= (WIDTH == 1);
            end

            if (state_q == StDrain && out_fire) begin
                if (idx_q == LastIdx) begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_data_q <= res_q[idx_nxt[IW-1:WB]][idx_nxt[WB-1:0]];
                    out_last_q <= (idx_nxt == LastIdx);
                end
            end
        end
    end

endmodule

// File: tb/tb_element_op_stream.sv
module tb_element_op_stream;
    import element_op_pkg::*;

    localparam int W = 4;
    localparam int N = W * W;
    // Values the stand-in element ops return for a zero divisor.
    localparam logic [31:0] DIV_Z = 32'hDEAD_0000;
    localparam logic [31:0] MOD_Z = 32'h0000_BEEF;
`ifdef ELEMENT_DIV0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready, out_last, busy, err_div0;
    logic [31:0] in_data, out_data;
    logic [2:0]  in_op;
    logic [0:W-1][0:W-1][31:0] mat_a, mat_b;
    logic [0:W-1][0:W-1][31:0] res_add, res_sub, res_mul, res_div, res_mod;

    always #5 clk = ~clk;

    element_op_stream #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .res_add   (res_add),
        .res_sub   (res_sub),
        .res_mul   (res_mul),
        .res_div   (res_div),
        .res_mod   (res_mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err_div0  (err_div0)
    );

    // Stand-in for the element-op datapath fed by mat_a/mat_b.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                res_add[i][j] = mat_a[i][j] + mat_b[i][j];
                res_sub[i][j] = mat_a[i][j] - mat_b[i][j];
                res_mul[i][j] = mat_a[i][j] * mat_b[i][j];
                res_div[i][j] = (mat_b[i][j] == 0) ? DIV_Z : mat_a[i][j] / mat_b[i][j];
                res_mod[i][j] = (mat_b[i][j] == 0) ? MOD_Z : mat_a[i][j] % mat_b[i][j];
            end
        end
    end

    int checks = 0;
    int failures = 0;

    logic [31:0] a_v[N];
    logic [31:0] b_v[N];
    logic [31:0] exp_v[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_elem(input int op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a * b;
            3: return (b == 0) ? (GUARD ? 32'hFFFF_FFFF : DIV_Z) : a / b;
            4: return (b == 0) ? (GUARD ? a : MOD_Z) : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Streams A then B; leaves time at the negedge of the first DRAIN cycle.
    task automatic send_job(input int op, input int gap_pct, input bit scramble);
        int k = 0;
        int cyc = 0;
        while (k < 2 * N && cyc < 1000) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = (k < N) ? a_v[k] : b_v[k - N];
            in_op    = (k == 0 || !scramble) ? 3'(op) : 3'($urandom_range(0, 7));
            if (in_valid && in_ready) k++;
            cyc++;
        end
        check("load_beats", k, 2 * N);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("exec_out_valid", out_valid, 1'b0);
        check("exec_busy", busy, 1'b1);
        check("exec_in_ready", in_ready, 1'b0);
        @(negedge clk);
        check("first_out_valid", out_valid, 1'b1);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
    // abort_at >= 0 asserts reset while that word is presented.
    task automatic drain(input int mode, input int abort_at);
        int got = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        while (got < N && cyc < 300) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (got == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_out_valid", out_valid, 1'b0);
                check("abort_out_last", out_last, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_in_ready_rst", in_ready, 1'b0);
                rst = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                check("abort_in_ready", in_ready, 1'b1);
                return;
            end
            check("drain_valid", out_valid, 1'b1);
            check("drain_in_ready", in_ready, 1'b0);
            if (prev_stall) check("stall_hold", out_data, prev_data);
            if (out_valid && out_ready) begin
                check($sformatf("word%0d", got), out_data, exp_v[got]);
                check($sformatf("last%0d", got), out_last, got == N - 1);
                got++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = out_valid;
            end
            prev_data = out_data;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_words", got, N);
        check("post_in_ready", in_ready, 1'b1);
        check("post_out_valid", out_valid, 1'b0);
        check("post_busy", busy, 1'b0);
    endtask

    task automatic run_job(input int op, input int gap_pct, input bit scramble, input int mode);
        bit any_zero = 1'b0;
        bit ok_a = 1'b1;
        bit ok_b = 1'b1;
        for (int k = 0; k < N; k++) begin
            exp_v[k] = ref_elem(op, a_v[k], b_v[k]);
            if (b_v[k] == 0) any_zero = 1'b1;
        end
        send_job(op, gap_pct, scramble);
        drain(mode, -1);
        check("err_div0", err_div0, GUARD && (op == 3 || op == 4) && any_zero);
        for (int k = 0; k < N; k++) begin
            if (mat_a[k / W][k % W] !== a_v[k]) ok_a = 1'b0;
            if (mat_b[k / W][k % W] !== b_v[k]) ok_b = 1'b0;
        end
        check("mat_a_hold", ok_a, 1'b1);
        check("mat_b_hold", ok_b, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_div0, 1'b0);
        check("rst_mats_zero", (mat_a == '0) && (mat_b == '0), 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1'b1);

        // ADD: A[k]=k, B=100
        for (int k = 0; k < N; k++) begin a_v[k] = k; b_v[k] = 100; end
        run_job(0, 0, 1'b0, 0);

        // SUB wrap
        for (int k = 0; k < N; k++) begin a_v[k] = 0; b_v[k] = 1; end
        run_job(1, 0, 1'b0, 0);

        // DIV / MOD with a zero divisor at [1][2]
        for (int k = 0; k < N; k++) begin a_v[k] = 10; b_v[k] = 2; end
        b_v[6] = 0;
        run_job(3, 0, 1'b0, 0);
        run_job(4, 0, 1'b0, 0);

        // Backpressure during drain, random data
        for (int k = 0; k < N; k++) begin a_v[k] = $urandom; b_v[k] = $urandom; end
        run_job(0, 0, 1'b0, 1);
        for (int k = 0; k < N; k++) begin a_v[k] = $urandom; b_v[k] = $urandom; end
        run_job(2, 20, 1'b1, 1);

        // MUL with input gaps and opcode churn after beat 0
        for (int k = 0; k < N; k++) begin a_v[k] = k; b_v[k] = 3; end
        run_job(2, 40, 1'b1, 0);

        // Random DIV with random divisors (some possibly small)
        for (int k = 0; k < N; k++) begin
            a_v[k] = $urandom;
            b_v[k] = $urandom_range(0, 3);
        end
        run_job(3, 10, 1'b0, 0);

        // Reset in the middle of a drain
        for (int k = 0; k < N; k++) begin
            a_v[k] = $urandom; b_v[k] = $urandom;
            exp_v[k] = ref_elem(0, a_v[k], b_v[k]);
        end
        send_job(0, 0, 1'b0);
        drain(0, 7);
        check("abort_mats_zero", (mat_a == '0) && (mat_b == '0), 1'b1);

        // Fresh ADD after reset, then an unused opcode
        for (int k = 0; k < N; k++) begin a_v[k] = $urandom; b_v[k] = $urandom; end
        run_job(0, 25, 1'b0, 0);
        for (int k = 0; k < N; k++) begin a_v[k] = $urandom; b_v[k] = $urandom; end
        run_job(6, 0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
